u_lsu: RTL

- Load/store unit directly downstream of the execute stage.
- Accepts one registered memory request per transaction (address, byte-mask write/read strobes, write data) and drives a req/gnt/rvalid data-memory port.
- Aligns write data and byte enables to the addressed lanes. Aligns and sign/zero-extends load data.
- Returns the load result with a one-cycle valid pulse. Asserts busy while a transaction is outstanding.

---
 rtl/lsu_pkg.sv | 34 +++
 rtl/lsu_align.sv | 23 ++
 rtl/u_lsu.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit.
// LSU_MISALIGN_CHK_EN (optional) enables the misalignment check in u_lsu.
package lsu_pkg;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} lsu_st_e;

  localparam logic [3:0] MSK_B = 4'b0001;
  localparam logic [3:0] MSK_H = 4'b0011;
  localparam logic [3:0] MSK_W = 4'b1111;

  // Extract the low byte/half of an already lane-shifted word and extend it.
  function automatic logic [31:0] lsu_ld_ext(input logic [31:0] sh,
                                             input logic [3:0]  msk,
                                             input logic        sext);
    logic [31:0] r;
    if (msk == MSK_B)      r = {{24{sext & sh[7]}}, sh[7:0]};
    else if (msk == MSK_H) r = {{16{sext & sh[15]}}, sh[15:0]};
    else                   r = sh;
    return r;
  endfunction

  function automatic logic lsu_misaligned(input logic [3:0] msk,
                                          input logic [1:0] off);
    logic r;
    case (msk)
      MSK_H:   r = off[0];
      MSK_W:   r = (off != 2'd0);
      4'b0111, 4'b0101, 4'b1001, 4'b1010, 4'b1011, 4'b1101: r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane alignment: shifts store mask/data up to the addressed
// lanes, and shifts load data down then extends it.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [3:0]  msk_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] wd_i,
  output logic [3:0]  be_o,
  output logic [31:0] wd_o,
  input  logic [1:0]  roff_i,
  input  logic [3:0]  rmsk_i,
  input  logic        rsext_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] rd_o
);

  // Lanes shifted past byte 3 fall off the 4-bit result.
  assign be_o = msk_i << off_i;
  assign wd_o = wd_i << {off_i, 3'b000};
  assign rd_o = lsu_ld_ext(rdata_i >> {roff_i, 3'b000}, rmsk_i, rsext_i);

endmodule

// File: rtl/u_lsu.sv
// Load/store unit: one outstanding req/gnt/rvalid transaction with timeout.
// Define LSU_MISALIGN_CHK_EN to reject misaligned requests without a dm_req.
module u_lsu
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYC = 255,
  parameter int CNT_W       = 8
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] lsu_a,
  input  logic [3:0]  lsu_we,
  input  logic [31:0] lsu_wd,
  input  logic [3:0]  lsu_re,
  input  logic        lsu_sext,
  output logic        lsu_busy,
  output logic        lsu_vld,
  output logic [31:0] lsu_rd,
  output logic        lsu_err,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_a,
  output logic [3:0]  dm_be,
  output logic [31:0] dm_wd,
  input  logic        dm_gnt,
  input  logic        dm_rvalid,
  input  logic [31:0] dm_rdata
);

  lsu_st_e          st_q, st_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      a_q, a_d, wd_q, wd_d, rd_q, rd_d;
  logic [3:0]       be_q, be_d, msk_q, msk_d;
  logic [1:0]       off_q, off_d;
  logic             we_q, we_d, sext_q, sext_d, err_q, err_d;

  logic        st_req, ld_req, tmo;
  logic [3:0]  msk_in, be_al;
  logic [31:0] wd_al, ld_res;

  // A store mask takes priority over a simultaneous load mask.
  assign st_req = |lsu_we;
  assign ld_req = |lsu_re;
  assign msk_in = st_req ? lsu_we : lsu_re;
  assign tmo    = (cnt_q == CNT_W'(TIMEOUT_CYC));

  lsu_align u_align (
    .msk_i   (msk_in),
    .off_i   (lsu_a[1:0]),
    .wd_i    (lsu_wd),
    .be_o    (be_al),
    .wd_o    (wd_al),
    .roff_i  (off_q),
    .rmsk_i  (msk_q),
    .rsext_i (sext_q),
    .rdata_i (dm_rdata),
    .rd_o    (ld_res)
  );

  always_comb begin
    st_d   = st_q;
    cnt_d  = cnt_q;
    a_d    = a_q;
    wd_d   = wd_q;
    rd_d   = rd_q;
    be_d   = be_q;
    msk_d  = msk_q;
    off_d  = off_q;
    we_d   = we_q;
    sext_d = sext_q;
    err_d  = err_q;
    case (st_q)
      IDLE: begin
        cnt_d = '0;
        if (st_req || ld_req) begin
          a_d    = {lsu_a[31:2], 2'b00};
          be_d   = be_al;
          wd_d   = wd_al;
          we_d   = st_req;
          off_d  = lsu_a[1:0];
          msk_d  = msk_in;
          sext_d = lsu_sext;
          rd_d   = '0;
          err_d  = 1'b0;
          st_d   = REQ;
`ifdef LSU_MISALIGN_CHK_EN
          if (lsu_misaligned(msk_in, lsu_a[1:0])) begin
            err_d = 1'b1;
            st_d  = RESP;
          end
`endif
        end
      end
      REQ: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (dm_gnt) begin
          cnt_d = '0;
          st_d  = we_q ? RESP : WAIT;
        end else if (tmo) begin
          err_d = 1'b1;
          st_d  = RESP;
        end
      end
      WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (dm_rvalid) begin
          rd_d = ld_res;
          st_d = RESP;
        end else if (tmo) begin
          err_d = 1'b1;
          st_d  = RESP;
        end
      end
      RESP: begin
        cnt_d = '0;
        st_d  = IDLE;
      end
      default: st_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      st_q   <= IDLE;
      cnt_q  <= '0;
      a_q    <= '0;
      wd_q   <= '0;
      rd_q   <= '0;
      be_q   <= '0;
      msk_q  <= '0;
      off_q  <= '0;
      we_q   <= 1'b0;
      sext_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      a_q    <= a_d;
      wd_q   <= wd_d;
      rd_q   <= rd_d;
      be_q   <= be_d;
      msk_q  <= msk_d;
      off_q  <= off_d;
      we_q   <= we_d;
      sext_q <= sext_d;
      err_q  <= err_d;
    end
  end

  assign dm_req   = (st_q == REQ);
  assign dm_we    = we_q;
  assign dm_a     = a_q;
  assign dm_be    = be_q;
  assign dm_wd    = wd_q;
  assign lsu_busy = (st_q != IDLE);
  assign lsu_vld  = (st_q == RESP);
  assign lsu_rd   = lsu_vld ? rd_q : '0;
  assign lsu_err  = lsu_vld & err_q;

endmodule
